pit_bus_master: RTL and testbench
=================================

Name: pit_bus_master

Overview:
- Upstream bus-cycle sequencer that drives the three-counter interval timer's CPU-side pins (CS, RD, WR, A1:A0, 8-bit data) from a simple valid/ready request port on the system clock.
- Converts single-cycle host requests into timed byte bus cycles with setup, strobe, hold and recovery phases.
- Sequences 16-bit counter accesses as two consecutive byte cycles, LSB first, as the timer's read/write-LSB-then-MSB mode requires.
- Returns read data on a one-cycle response pulse.
- The data tristate lives at the chip top; this block exposes separate dout/dout_en/din.

Parameters:
- SETUP_CYC, 1: cycles CS and address are valid before the strobe (min 1).
- STROBE_CYC, 2: cycles RD_n or WR_n is held low (min 1).
- HOLD_CYC, 1: cycles CS, address and write data stay valid after the strobe rises (min 1).
- RECOVER_CYC, 2: cycles CS is high between consecutive byte cycles (min 1).
- CNT_W, 3: width of the shared phase counter; must hold max(param)-1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request; high only in IDLE.
- req_write, input, 1: 1 = write, 0 = read.
- req_addr, input, 2: 0/1/2 = counter 0/1/2, 3 = control word.
- req_word, input, 1: 1 = 16-bit access as two bytes, LSB first.
- req_wdata, input, 16: write data; [7:0] is used for byte access.
- rsp_valid, output, 1: one-cycle completion pulse for reads and writes.
- rsp_rdata, output, 16: read data; for byte reads {8'h00, byte}; held until the next response.
- pit_cs_n, output, 1: chip select, active low.
- pit_rd_n, output, 1: read strobe, active low.
- pit_wr_n, output, 1: write strobe, active low.
- pit_a, output, 2: A1:A0.
- pit_dout, output, 8: write byte.
- pit_dout_en, output, 1: top-level tristate enable for pit_dout.
- pit_din, input, 8: bus data as seen on the inout pins.

Behaviour:
- **Reset values:**
  - req_ready=0 during reset, 1 in the first cycle after reset.
  - rsp_valid=0, rsp_rdata=0.
  - pit_cs_n=pit_rd_n=pit_wr_n=1, pit_a=0, pit_dout=0, pit_dout_en=0.
- **Reset mid-transaction:** all strobes return high at the next edge and the in-flight request is dropped with no response.
- **Output timing:** all outputs are registered, with no combinational path from inputs to outputs.
- **FSM:** IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> (IDLE | SETUP).
  - Each phase lasts its parameter count, timed by one down-counter reloaded on each phase entry.
- **Accept:** a request is taken on the edge where req_valid & req_ready. All request fields are captured into registers.
- **SETUP:** cs_n=0, pit_a=captured address. For writes, dout_en=1 and dout=current byte. rd_n=wr_n=1.
- **STROBE:** as SETUP, plus rd_n=0 (read) or wr_n=0 (write).
- **HOLD:** strobes high; cs_n, address and dout/dout_en unchanged.
- **RECOVER:** cs_n=1, dout_en=0, address held.
- **Read sampling:** pit_din is captured on the edge that ends the last STROBE cycle.
  - Byte 0 goes to rdata[7:0], byte 1 to rdata[15:8].
- **Byte count:**
  - Word access performs byte 0 (LSB) and then byte 1 (MSB). After the first RECOVER it goes to SETUP, not IDLE.
  - byte_sel selects req_wdata[7:0] or [15:8].
- **Control address:** req_word with req_addr=3 is executed as a single byte access; the upper byte is ignored.
- **Response:** rsp_valid pulses high during the first RECOVER cycle of the final byte. rsp_rdata updates in that same cycle for reads and is unchanged for writes.
- **Default latency** (accept at edge k):
  - SETUP k+1, STROBE k+2..k+3, HOLD k+4, RECOVER k+5..k+6.
  - rsp_valid at k+5, req_ready at k+7.
  - Word access: rsp_valid at k+11, ready at k+13.
- **Backpressure:** req_valid while busy is ignored; there is no queueing.

Decomposition:
- Shared package pit_pkg:
  - state enum (IDLE, SETUP, STROBE, HOLD, RECOVER).
  - address constants PIT_CNT0..PIT_CNT2 and PIT_CTRL=2'd3.
- Single module; no sub-module is needed. The phase counter stays inline.

Test Plan:
1. **Byte write control:** req addr=3, write, wdata=16'h0034.
   - wr_n low exactly 2 cycles; cs_n low 4 cycles.
   - pit_a=3, dout=8'h34 with dout_en high in SETUP..HOLD.
   - rsp_valid at k+5; ready at k+7.
2. **Word write counter 0:** wdata=16'h1234, req_word=1.
   - Two bus cycles: dout=8'h34 then 8'h12.
   - cs_n high for 2 cycles between them; a single rsp_valid at k+11.
3. **Word read counter 2:** pit_din model returns 8'hCD then 8'hAB.
   - rsp_rdata=16'hABCD with rsp_valid; rd_n low 2 cycles per byte; dout_en stays 0.
4. **Byte read counter 1:** din=8'h5A.
   - rsp_rdata=16'h005A.
5. **Word to control:** req_word=1, addr=3, wdata=16'hFF76.
   - One byte cycle with dout=8'h76; response at k+5.
6. **Reset and busy:**
   - Assert rst during STROBE: the next cycle has wr_n=cs_n=1, dout_en=0, no rsp_valid, and req_ready=1 after rst drops.
   - Hold req_valid high while busy: exactly one transaction is performed per accept.

Source files
------------

// File: rtl/pit_pkg.sv
// Shared types and address constants for the interval-timer bus master.
package pit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    localparam logic [1:0] PIT_CNT0 = 2'd0;
    localparam logic [1:0] PIT_CNT1 = 2'd1;
    localparam logic [1:0] PIT_CNT2 = 2'd2;
    localparam logic [1:0] PIT_CTRL = 2'd3;

endpackage

// File: rtl/pit_bus_master.sv
// Turns single-cycle valid/ready requests into timed timer bus cycles (setup/strobe/hold/recover).
// Byte access: rsp 5 cycles, ready 7 cycles after accept; word access: 11 / 13. Busy requests are ignored.
module pit_bus_master
    import pit_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2,
    parameter int CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_addr,
    input  logic        req_word,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        pit_cs_n,
    output logic        pit_rd_n,
    output logic        pit_wr_n,
    output logic [1:0]  pit_a,
    output logic [7:0]  pit_dout,
    output logic        pit_dout_en,
    input  logic [7:0]  pit_din
);

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             write_q;
    logic             word_q;
    logic             byte_sel;
    logic [7:0]       wdata_hi;
    logic [15:0]      rbuf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            write_q     <= 1'b0;
            word_q      <= 1'b0;
            byte_sel    <= 1'b0;
            wdata_hi    <= 8'h00;
            rbuf        <= 16'h0000;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 16'h0000;
            pit_cs_n    <= 1'b1;
            pit_rd_n    <= 1'b1;
            pit_wr_n    <= 1'b1;
            pit_a       <= 2'd0;
            pit_dout    <= 8'h00;
            pit_dout_en <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        write_q     <= req_write;
                        // The control register is 8 bits wide, so a word request to it is a single byte.
                        word_q      <= req_word && (req_addr != PIT_CTRL);
                        wdata_hi    <= req_wdata[15:8];
                        byte_sel    <= 1'b0;
                        rbuf        <= 16'h0000;
                        state       <= SETUP;
                        cnt         <= SETUP_LD;
                        pit_cs_n    <= 1'b0;
                        pit_a       <= req_addr;
                        pit_dout_en <= req_write;
                        if (req_write) begin
                            pit_dout <= req_wdata[7:0];
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state    <= STROBE;
                        cnt      <= STROBE_LD;
                        pit_rd_n <= write_q;
                        pit_wr_n <= !write_q;
                    end
                end
                STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state    <= HOLD;
                        cnt      <= HOLD_LD;
                        pit_rd_n <= 1'b1;
                        pit_wr_n <= 1'b1;
                        // Latch read data on the edge that releases the strobe.
                        if (!write_q) begin
                            if (byte_sel) begin
                                rbuf[15:8] <= pit_din;
                            end else begin
                                rbuf[7:0] <= pit_din;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state       <= RECOVER;
                        cnt         <= RECOVER_LD;
                        pit_cs_n    <= 1'b1;
                        pit_dout_en <= 1'b0;
                        if (!word_q || byte_sel) begin
                            rsp_valid <= 1'b1;
                            if (!write_q) begin
                                rsp_rdata <= rbuf;
                            end
                        end
                    end
                end
                RECOVER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (word_q && !byte_sel) begin
                        byte_sel    <= 1'b1;
                        state       <= SETUP;
                        cnt         <= SETUP_LD;
                        pit_cs_n    <= 1'b0;
                        pit_dout_en <= write_q;
                        if (write_q) begin
                            pit_dout <= wdata_hi;
                        end
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pit_bus_master.sv
// Directed table-driven bench for pit_bus_master with a simple timer data-bus model.
module tb_pit_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_addr;
    logic        req_word;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        pit_cs_n;
    logic        pit_rd_n;
    logic        pit_wr_n;
    logic [1:0]  pit_a;
    logic [7:0]  pit_dout;
    logic        pit_dout_en;
    logic [7:0]  pit_din;

    pit_bus_master dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_word    (req_word),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .pit_cs_n    (pit_cs_n),
        .pit_rd_n    (pit_rd_n),
        .pit_wr_n    (pit_wr_n),
        .pit_a       (pit_a),
        .pit_dout    (pit_dout),
        .pit_dout_en (pit_dout_en),
        .pit_din     (pit_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  addr;
        logic        word;
        logic [15:0] wdata;
        logic [7:0]  din_lo;
        logic [7:0]  din_hi;
        int          exp_rsp;
        int          exp_ready;
        int          exp_cs;
        int          exp_stb;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int passed = 0;

    // Per-transaction observations
    int          rsp_cyc1, rsp_cyc2, rsp_cnt, ready_cyc;
    int          cs_low, wr_low, rd_low, bus_err, gap;
    logic [15:0] seen_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run(input vec_t v, input int vhold, input int win);
        int   w;
        logic prev_cs;
        int   bidx;
        bit   seen2;
        logic [7:0] exp_byte;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({v.name, "_ready_before"}, req_ready, 1);
        req_write = v.wr;
        req_addr  = v.addr;
        req_word  = v.word;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        pit_din   = v.din_lo;
        @(posedge clk);
        rsp_cyc1 = -1; rsp_cyc2 = -1; rsp_cnt = 0; ready_cyc = -1;
        cs_low = 0; wr_low = 0; rd_low = 0; bus_err = 0; gap = 0;
        seen_rdata = 16'hxxxx;
        prev_cs = 1'b1; bidx = 0; seen2 = 1'b0;
        for (int cyc = 1; cyc <= win; cyc++) begin
            @(negedge clk);
            if (cyc == vhold) req_valid = 1'b0;
            if (pit_cs_n && !prev_cs) bidx++;
            if (!pit_cs_n && bidx >= 1) seen2 = 1'b1;
            if (pit_cs_n && bidx >= 1 && !seen2) gap++;
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc1 < 0) rsp_cyc1 = cyc;
                else if (rsp_cyc2 < 0) rsp_cyc2 = cyc;
                seen_rdata = rsp_rdata;
            end
            if (req_ready && ready_cyc < 0) ready_cyc = cyc;
            exp_byte = (bidx == 0) ? v.wdata[7:0] : v.wdata[15:8];
            if (!pit_cs_n) begin
                cs_low++;
                if (pit_a !== v.addr) bus_err++;
                if (v.wr && (pit_dout_en !== 1'b1 || pit_dout !== exp_byte)) bus_err++;
                if (!v.wr && pit_dout_en !== 1'b0) bus_err++;
            end else begin
                if (pit_dout_en !== 1'b0) bus_err++;
                if (!pit_wr_n || !pit_rd_n) bus_err++;
            end
            if (!pit_wr_n) wr_low++;
            if (!pit_rd_n) rd_low++;
            pit_din = (bidx == 0) ? v.din_lo : v.din_hi;
            prev_cs = pit_cs_n;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"byte_wr_ctrl",  1'b1, 2'd3, 1'b0, 16'h0034, 8'h00, 8'h00, 5,  7,  4, 2, 16'h0000};
        vecs[1] = '{"word_wr_cnt0",  1'b1, 2'd0, 1'b1, 16'h1234, 8'h00, 8'h00, 11, 13, 8, 4, 16'h0000};
        vecs[2] = '{"word_rd_cnt2",  1'b0, 2'd2, 1'b1, 16'h0000, 8'hCD, 8'hAB, 11, 13, 8, 4, 16'hABCD};
        vecs[3] = '{"byte_rd_cnt1",  1'b0, 2'd1, 1'b0, 16'h0000, 8'h5A, 8'h77, 5,  7,  4, 2, 16'h005A};
        vecs[4] = '{"word_wr_ctrl",  1'b1, 2'd3, 1'b1, 16'hFF76, 8'h00, 8'h00, 5,  7,  4, 2, 16'h005A};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0;
        req_word = 1'b0; req_wdata = 16'h0000; pit_din = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_strobes", {pit_cs_n, pit_rd_n, pit_wr_n}, 3'b111);
        chk("rst_bus", {pit_a, pit_dout, pit_dout_en}, 11'h000);
        chk("rst_rsp", {rsp_valid, rsp_rdata}, 17'h00000);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);

        for (int i = 0; i < 5; i++) begin
            run(vecs[i], 1, 16);
            chk({vecs[i].name, "_rsp_cyc"},  rsp_cyc1,  vecs[i].exp_rsp);
            chk({vecs[i].name, "_rsp_cnt"},  rsp_cnt,   1);
            chk({vecs[i].name, "_rdata"},    seen_rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, "_ready_cyc"}, ready_cyc, vecs[i].exp_ready);
            chk({vecs[i].name, "_cs_low"},   cs_low,    vecs[i].exp_cs);
            chk({vecs[i].name, "_wr_low"},   wr_low,    vecs[i].wr ? vecs[i].exp_stb : 0);
            chk({vecs[i].name, "_rd_low"},   rd_low,    vecs[i].wr ? 0 : vecs[i].exp_stb);
            chk({vecs[i].name, "_bus"},      bus_err,   0);
            if (vecs[i].exp_cs == 8) chk({vecs[i].name, "_gap"}, gap, 2);
        end

        // Reset in the middle of a write strobe drops the request.
        @(negedge clk);
        req_write = 1'b1; req_addr = 2'd0; req_word = 1'b0; req_wdata = 16'h00EE;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_strobe_wr_n", pit_wr_n, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_strobes", {pit_cs_n, pit_wr_n, pit_rd_n, pit_dout_en}, 4'b1110);
        chk("mid_rst_rsp", rsp_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_rdata", {rsp_valid, rsp_rdata}, 17'h00000);

        // Valid held high across a busy period: one transaction per accept.
        run('{"busy", 1'b1, 2'd1, 1'b0, 16'h4242, 8'h00, 8'h00, 5, 7, 4, 2, 16'h0000}, 13, 20);
        chk("busy_rsp1", rsp_cyc1, 5);
        chk("busy_rsp2", rsp_cyc2, 12);
        chk("busy_rsp_cnt", rsp_cnt, 2);
        chk("busy_cs_low", cs_low, 8);
        chk("busy_wr_low", wr_low, 4);
        chk("busy_bus", bus_err, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
